vec_alu_sequencer: RTL and testbench

- Element sequencer directly upstream of the lane ALU.
- Accepts one vector instruction through a valid/ready handshake. Walks elements 0..vl-1, reads operands from the vector register file, drives ALU operands and controls, then writes ALU results back.
- Collects ALU predicate bits into a per-element mask register.
- Throughput is one element per cycle after a 1-cycle pipeline fill.

---
 rtl/vec_alu_sequencer_if.sv | 57 +++++
 rtl/vec_alu_sequencer.sv | 107 ++++++++++
 tb/tb_vec_alu_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vec_alu_sequencer_if.sv
// vec_alu_sequencer_if: instruction handshake, register-file and lane-ALU signals of the element sequencer.
interface vec_alu_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int VLMAX = 8
);
  localparam int EW = $clog2(VLMAX);
  logic             instr_valid;
  logic             instr_ready;
  logic [4:0]       instr_vd;
  logic [4:0]       instr_vs1;
  logic [4:0]       instr_vs2;
  logic [WIDTH-1:0] instr_scalar;
  logic [EW:0]      instr_vl;
  logic             instr_addsub;
  logic             instr_mux;
  logic [2:0]       instr_out_ctrl;
  logic [1:0]       instr_bit_ctrl;
  logic [3:0]       instr_comp_ctrl;
  logic             instr_mask_wr;
  logic             instr_masked;
  logic [4+EW:0]    rf_rd_addr1;
  logic [4+EW:0]    rf_rd_addr2;
  logic [WIDTH-1:0] rf_rd_data1;
  logic [WIDTH-1:0] rf_rd_data2;
  logic             rf_wr_en;
  logic [4+EW:0]    rf_wr_addr;
  logic [WIDTH-1:0] rf_wr_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_c;
  logic             alu_addsub;
  logic             alu_mux;
  logic [2:0]       alu_out_ctrl;
  logic [1:0]       alu_bit_ctrl;
  logic [3:0]       alu_comp_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_predicate;
  logic             busy;
  logic             done;
  logic [VLMAX-1:0] mask_out;
  modport master (
    output instr_valid, instr_vd, instr_vs1, instr_vs2, instr_scalar, instr_vl, instr_addsub,
           instr_mux, instr_out_ctrl, instr_bit_ctrl, instr_comp_ctrl, instr_mask_wr, instr_masked,
           rf_rd_data1, rf_rd_data2, alu_result, alu_predicate,
    input  instr_ready, rf_rd_addr1, rf_rd_addr2, rf_wr_en, rf_wr_addr, rf_wr_data,
           alu_a, alu_b, alu_c, alu_addsub, alu_mux, alu_out_ctrl, alu_bit_ctrl, alu_comp_ctrl,
           busy, done, mask_out
  );
  modport slave (
    input  instr_valid, instr_vd, instr_vs1, instr_vs2, instr_scalar, instr_vl, instr_addsub,
           instr_mux, instr_out_ctrl, instr_bit_ctrl, instr_comp_ctrl, instr_mask_wr, instr_masked,
           rf_rd_data1, rf_rd_data2, alu_result, alu_predicate,
    output instr_ready, rf_rd_addr1, rf_rd_addr2, rf_wr_en, rf_wr_addr, rf_wr_data,
           alu_a, alu_b, alu_c, alu_addsub, alu_mux, alu_out_ctrl, alu_bit_ctrl, alu_comp_ctrl,
           busy, done, mask_out
  );
endinterface

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: walks vector elements through RF read -> lane ALU -> RF write/mask, one per cycle.
// Optional VEC_MASKED_EXEC_EN: predicated execution gated by the mask left by the previous op.
module vec_alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int VLMAX = 8
) (
  input logic clk,
  input logic rst_n,
  vec_alu_sequencer_if.slave bus
);
  localparam int EW = $clog2(VLMAX);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [4:0]       vd;
    logic [4:0]       vs1;
    logic [4:0]       vs2;
    logic [WIDTH-1:0] scalar;
    logic [EW:0]      vl;
    logic             addsub;
    logic             mux;
    logic [2:0]       out_ctrl;
    logic [1:0]       bit_ctrl;
    logic [3:0]       comp_ctrl;
    logic             mask_wr;
    logic             masked;
  } ins_t;
  state_t           state_q, state_d;
  ins_t             ins_q, ins_d;
  logic [EW-1:0]    rd_e_q, rd_e_d, s2_e_q, s2_e_d;
  logic             s2_valid_q, s2_valid_d, done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [VLMAX-1:0] mask_q, mask_d;
  logic             accept, run, last, wr_ok, masked_in;
  logic [EW:0]      vl_eff;
`ifdef VEC_MASKED_EXEC_EN
  assign masked_in = bus.instr_masked;
`else
  assign masked_in = 1'b0;
`endif
  always_comb begin
    accept     = state_q == IDLE && bus.instr_valid;
    run        = state_q == RUN;
    vl_eff     = bus.instr_vl > (EW+1)'(VLMAX) ? (EW+1)'(VLMAX) : bus.instr_vl;
    last       = {1'b0, rd_e_q} == ins_q.vl - 1'b1;
    wr_ok      = s2_valid_q && (!ins_q.masked || mask_q[s2_e_q]);
    ins_d      = accept ? ins_t'{vd: bus.instr_vd, vs1: bus.instr_vs1, vs2: bus.instr_vs2,
                                 scalar: bus.instr_scalar, vl: vl_eff, addsub: bus.instr_addsub,
                                 mux: bus.instr_mux, out_ctrl: bus.instr_out_ctrl,
                                 bit_ctrl: bus.instr_bit_ctrl, comp_ctrl: bus.instr_comp_ctrl,
                                 mask_wr: bus.instr_mask_wr, masked: masked_in} : ins_q;
    state_d    = accept ? (vl_eff == '0 ? DRAIN : RUN) :
                 run ? (last ? DRAIN : RUN) :
                 state_q == DRAIN ? IDLE : state_q;
    rd_e_d     = accept ? '0 : run ? rd_e_q + 1'b1 : rd_e_q;
    s2_valid_d = run;
    s2_e_d     = run ? rd_e_q : s2_e_q;
    a_d        = run ? bus.rf_rd_data1 : a_q;
    b_d        = run ? bus.rf_rd_data2 : b_q;
    done_d     = state_q == DRAIN;
    mask_d     = mask_q;
    // a predicated op keeps the previous mask so it can gate its own writes
    if (accept && !masked_in)
      mask_d = '0;
    else if (wr_ok && ins_q.mask_wr)
      mask_d[s2_e_q] = bus.alu_predicate;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ins_q      <= '0;
      rd_e_q     <= '0;
      s2_e_q     <= '0;
      s2_valid_q <= 1'b0;
      done_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      ins_q      <= ins_d;
      rd_e_q     <= rd_e_d;
      s2_e_q     <= s2_e_d;
      s2_valid_q <= s2_valid_d;
      done_q     <= done_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mask_q     <= mask_d;
    end
  end
  assign bus.instr_ready   = state_q == IDLE;
  assign bus.busy          = state_q != IDLE;
  assign bus.done          = done_q;
  assign bus.mask_out      = mask_q;
  assign bus.rf_rd_addr1   = {ins_q.vs1, rd_e_q};
  assign bus.rf_rd_addr2   = {ins_q.vs2, rd_e_q};
  assign bus.rf_wr_en      = wr_ok && !ins_q.mask_wr;
  assign bus.rf_wr_addr    = {ins_q.vd, s2_e_q};
  assign bus.rf_wr_data    = bus.alu_result;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;
  assign bus.alu_c         = ins_q.scalar;
  assign bus.alu_addsub    = ins_q.addsub;
  assign bus.alu_mux       = ins_q.mux;
  assign bus.alu_out_ctrl  = ins_q.out_ctrl;
  assign bus.alu_bit_ctrl  = ins_q.bit_ctrl;
  assign bus.alu_comp_ctrl = ins_q.comp_ctrl;
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb_vec_alu_sequencer: scoreboard bench with a behavioural register file and lane ALU around the sequencer.
module tb_vec_alu_sequencer;
  localparam int WIDTH = 32;
  localparam int VLMAX = 8;
  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rf [256];
  logic [31:0] opb;
  logic [7:0]  last_addr = '0;
  wr_t         sb[$];
  wr_t         mon_w;
  int          cyc = 0, n_chk = 0, n_pass = 0, done_cnt = 0, last_done = -1;
  int          n, n2, dc0;
  always #5 clk = ~clk;
  vec_alu_sequencer_if #(.WIDTH(WIDTH), .VLMAX(VLMAX)) bus ();
  vec_alu_sequencer #(.WIDTH(WIDTH), .VLMAX(VLMAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.rf_rd_data1   = rf[bus.rf_rd_addr1];
  assign bus.rf_rd_data2   = rf[bus.rf_rd_addr2];
  assign opb               = bus.alu_mux ? bus.alu_c : bus.alu_b;
  assign bus.alu_result    = bus.alu_addsub ? bus.alu_a - opb : bus.alu_a + opb;
  assign bus.alu_predicate = bus.alu_comp_ctrl == 4'b0100 ? bus.alu_a < opb : bus.alu_a == opb;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (bus.rf_wr_en) begin
      chk("wr_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_w = sb.pop_front();
        chk("wr_addr", bus.rf_wr_addr, mon_w.addr);
        chk("wr_data", bus.rf_wr_data, mon_w.data);
        chk("wr_cycle", cyc, mon_w.cyc);
      end
      last_addr = bus.rf_wr_addr;
    end
  end
  task automatic push(input int c, input logic [4:0] vd, input logic [2:0] e, input logic [31:0] d);
    sb.push_back('{c, {vd, e}, d});
  endtask
  task automatic send(input logic [4:0] vd, vs1, vs2, input logic [31:0] sc, input logic [3:0] vl,
                      input logic addsub, input logic [3:0] comp, input logic mwr, msk, output int acc);
    bus.instr_vd = vd; bus.instr_vs1 = vs1; bus.instr_vs2 = vs2; bus.instr_scalar = sc;
    bus.instr_vl = vl; bus.instr_addsub = addsub; bus.instr_comp_ctrl = comp;
    bus.instr_mask_wr = mwr; bus.instr_masked = msk; bus.instr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.instr_ready) break;
      @(negedge clk);
    end
    chk("accept_ready", bus.instr_ready, 1);
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int acc, input int vl);
    int dc = -1;
    for (int i = 0; i < 40 && dc < 0; i++) begin
      @(negedge clk);
      if (bus.done) dc = cyc;
    end
    chk(tag, dc, acc + 1 + vl);
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int e = 0; e < 8; e++) begin
      rf[{5'd1, 3'(e)}] = e + 1;
      rf[{5'd2, 3'(e)}] = 10 * (e + 1);
      rf[{5'd3, 3'(e)}] = e;
      rf[{5'd4, 3'(e)}] = 3;
      rf[{5'd5, 3'(e)}] = e % 2 ? 0 : 5;
    end
    bus.instr_valid = 0; bus.instr_vd = 0; bus.instr_vs1 = 0; bus.instr_vs2 = 0;
    bus.instr_scalar = 0; bus.instr_vl = 0; bus.instr_addsub = 0; bus.instr_mux = 0;
    bus.instr_out_ctrl = 3'b101; bus.instr_bit_ctrl = 2'b10; bus.instr_comp_ctrl = 0;
    bus.instr_mask_wr = 0; bus.instr_masked = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mask", bus.mask_out, 0);
    chk("rst_wr_en", bus.rf_wr_en, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_c", bus.alu_c, 0);
    chk("rst_out_ctrl", bus.alu_out_ctrl, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(5'd7, 5'd1, 5'd2, 32'h55, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, n);
    chk("add_busy", bus.busy, 1);
    chk("add_alu_c", bus.alu_c, 32'h55);
    chk("add_out_ctrl", bus.alu_out_ctrl, 3'b101);
    push(n + 1, 5'd7, 3'd0, 11); push(n + 2, 5'd7, 3'd1, 22);
    push(n + 3, 5'd7, 3'd2, 33); push(n + 4, 5'd7, 3'd3, 44);
    wait_done("add_done", n, 4);
    send(5'd12, 5'd3, 5'd4, 0, 4'd8, 1'b0, 4'b0100, 1'b1, 1'b0, n);
    chk("cmp_comp_ctrl", bus.alu_comp_ctrl, 4'b0100);
    wait_done("cmp_done", n, 8);
    chk("cmp_mask", bus.mask_out, 8'b0000_0111);
    send(5'd13, 5'd1, 5'd2, 0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, n);
    wait_done("vl0_done", n, 0);
    chk("vl0_mask", bus.mask_out, 0);
    send(5'd8, 5'd1, 5'd2, 0, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, n);
    for (int e = 0; e < 8; e++) push(n + 1 + e, 5'd8, 3'(e), 11 * (e + 1));
    wait_done("clamp_done", n, 8);
    chk("clamp_last_addr", last_addr, {5'd8, 3'd7});
    send(5'd9, 5'd1, 5'd2, 0, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, n);
    for (int e = 0; e < 4; e++) push(n + 1 + e, 5'd9, 3'(e), 11 * (e + 1));
    send(5'd10, 5'd1, 5'd2, 0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, n2);
    for (int e = 0; e < 3; e++) push(n2 + 1 + e, 5'd10, 3'(e), -9 * (e + 1));
    chk("b2b_first_done", last_done, n + 5);
    chk("b2b_accept", n2, last_done + 1);
    wait_done("b2b_done", n2, 3);
    dc0 = done_cnt;
    send(5'd11, 5'd1, 5'd2, 0, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0, n);
    push(n + 1, 5'd11, 3'd0, 11); push(n + 2, 5'd11, 3'd1, 22);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_wr_en", bus.rf_wr_en, 0);
    chk("midrst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", bus.done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_done_cnt", done_cnt, dc0);
    chk("midrst_sb", sb.size(), 0);
    chk("midrst_ready", bus.instr_ready, 1);
    send(5'd14, 5'd5, 5'd4, 0, 4'd8, 1'b0, 4'b0100, 1'b1, 1'b0, n);
    wait_done("premask_done", n, 8);
    chk("premask", bus.mask_out, 8'b1010_1010);
    send(5'd15, 5'd1, 5'd2, 0, 4'd8, 1'b0, 4'd0, 1'b0, 1'b1, n);
`ifdef VEC_MASKED_EXEC_EN
    for (int e = 1; e < 8; e += 2) push(n + 1 + e, 5'd15, 3'(e), 11 * (e + 1));
    wait_done("masked_done", n, 8);
    chk("masked_mask", bus.mask_out, 8'b1010_1010);
`else
    for (int e = 0; e < 8; e++) push(n + 1 + e, 5'd15, 3'(e), 11 * (e + 1));
    wait_done("masked_done", n, 8);
    chk("masked_mask", bus.mask_out, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
